// File: rtl/raid0_stripe_scheduler_pkg.sv
// Shared types and sizing helpers for the RAID-0 stripe scheduler.
// The chunk-length helper is used by the address map and any reassembly logic.
package raid0_stripe_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_NUM_DEV     = 2;
    localparam int DEF_STRIPE_BLKS = 8;
    localparam int DEF_LBA_W       = 32;
    localparam int DEF_BLKCNT_W    = 16;
    localparam int DEF_STRIPE_LOG2 = $clog2(DEF_STRIPE_BLKS);
    localparam int DEF_DEV_LOG2    = $clog2(DEF_NUM_DEV);

    // A chunk never exceeds one stripe, so its length needs log2(stripe)+1 bits.
    function automatic int chunk_len_w(input int stripe_blks);
        return $clog2(stripe_blks) + 1;
    endfunction

endpackage

// File: rtl/raid0_stripe_scheduler_if.sv
// Host request, per-device command/completion and status bundle of the stripe scheduler.
// The scheduler uses the slave view; the host/device side uses the master view.
interface raid0_stripe_scheduler_if
    import raid0_stripe_scheduler_pkg::*;
#(
    parameter int NUM_DEV  = DEF_NUM_DEV,
    parameter int LBA_W    = DEF_LBA_W,
    parameter int BLKCNT_W = DEF_BLKCNT_W
) ();

    logic                req_valid;
    logic                req_ready;
    logic [LBA_W-1:0]    req_lba;
    logic [BLKCNT_W-1:0] req_blkcnt;
    logic                req_write;

    logic [NUM_DEV-1:0]  dev_cmd_valid;
    logic [NUM_DEV-1:0]  dev_cmd_ready;
    logic [LBA_W-1:0]    dev_cmd_lba;
    logic [BLKCNT_W-1:0] dev_cmd_blkcnt;
    logic                dev_cmd_write;
    logic [NUM_DEV-1:0]  dev_done;
    logic [NUM_DEV-1:0]  dev_err;

    logic                busy_o;
    logic                done_o;
    logic                err_o;

    modport master (
        output req_valid, req_lba, req_blkcnt, req_write,
        output dev_cmd_ready, dev_done, dev_err,
        input  req_ready, dev_cmd_valid, dev_cmd_lba, dev_cmd_blkcnt, dev_cmd_write,
        input  busy_o, done_o, err_o
    );

    modport slave (
        input  req_valid, req_lba, req_blkcnt, req_write,
        input  dev_cmd_ready, dev_done, dev_err,
        output req_ready, dev_cmd_valid, dev_cmd_lba, dev_cmd_blkcnt, dev_cmd_write,
        output busy_o, done_o, err_o
    );

endinterface

// File: rtl/raid0_stripe_scheduler_addr_map.sv
// Combinational stripe mapping: array LBA and remaining count to target device,
// device-local LBA and chunk length clipped at the stripe boundary.
module raid0_stripe_scheduler_addr_map
    import raid0_stripe_scheduler_pkg::*;
#(
    parameter int NUM_DEV     = DEF_NUM_DEV,
    parameter int STRIPE_BLKS = DEF_STRIPE_BLKS,
    parameter int LBA_W       = DEF_LBA_W,
    parameter int BLKCNT_W    = DEF_BLKCNT_W,
    parameter int DEV_W       = $clog2(NUM_DEV)
) (
    input  logic [LBA_W-1:0]    cur,
    input  logic [BLKCNT_W-1:0] rem,
    output logic [DEV_W-1:0]    dev,
    output logic [LBA_W-1:0]    dlba,
    output logic [BLKCNT_W-1:0] len
);

    localparam int STRIPE_LOG2 = $clog2(STRIPE_BLKS);
    localparam int DEV_LOG2    = $clog2(NUM_DEV);
    localparam int LEN_W       = chunk_len_w(STRIPE_BLKS);

    logic [STRIPE_LOG2-1:0] off;
    logic [LBA_W-1:0]       stripe_idx;
    logic [LEN_W-1:0]       room;

    // Both sizes are powers of two, so div/mod reduce to shifts and bit slices.
    always_comb begin
        off        = cur[STRIPE_LOG2-1:0];
        stripe_idx = cur >> STRIPE_LOG2;
        dev        = stripe_idx[DEV_W-1:0];
        dlba       = ((stripe_idx >> DEV_LOG2) << STRIPE_LOG2) | LBA_W'(off);
        room       = LEN_W'(STRIPE_BLKS) - LEN_W'(off);
        len        = (rem < BLKCNT_W'(room)) ? rem : BLKCNT_W'(room);
    end

endmodule

// File: rtl/raid0_stripe_scheduler.sv
// RAID-0 stripe scheduler: splits one host request into stripe chunks, issues them to
// single-command eMMC cores and reports one done/err once every chunk has retired.
module raid0_stripe_scheduler
    import raid0_stripe_scheduler_pkg::*;
#(
    parameter int NUM_DEV     = DEF_NUM_DEV,
    parameter int STRIPE_BLKS = DEF_STRIPE_BLKS,
    parameter int LBA_W       = DEF_LBA_W,
    parameter int BLKCNT_W    = DEF_BLKCNT_W
) (
    input logic clk,
    input logic rst_n,
    raid0_stripe_scheduler_if.slave bus
);

    localparam int DEV_W = $clog2(NUM_DEV);

    state_t state, state_nxt;

    logic [LBA_W-1:0]    cur;
    logic [BLKCNT_W-1:0] rem;
    logic                write_q;
    logic [DEV_W-1:0]    dev_q;
    logic [LBA_W-1:0]    dlba_q;
    logic [BLKCNT_W-1:0] len_q;
    logic [NUM_DEV-1:0]  pending;
    logic                err_sticky;

    logic [DEV_W-1:0]    map_dev;
    logic [LBA_W-1:0]    map_dlba;
    logic [BLKCNT_W-1:0] map_len;

    logic                accept;
    logic                issue_ok;
    logic                fire;
    logic [NUM_DEV-1:0]  fire_vec;
    logic [NUM_DEV-1:0]  done_hit;
    logic [BLKCNT_W-1:0] rem_after;

    raid0_stripe_scheduler_addr_map #(
        .NUM_DEV     (NUM_DEV),
        .STRIPE_BLKS (STRIPE_BLKS),
        .LBA_W       (LBA_W),
        .BLKCNT_W    (BLKCNT_W),
        .DEV_W       (DEV_W)
    ) u_addr_map (
        .cur  (cur),
        .rem  (rem),
        .dev  (map_dev),
        .dlba (map_dlba),
        .len  (map_len)
    );

    // A chunk may only be offered to an idle core, and never once a chunk has failed.
    always_comb begin
        accept    = (state == ST_IDLE) && bus.req_valid;
        issue_ok  = (state == ST_ISSUE) && !pending[dev_q] && !err_sticky;
        fire      = issue_ok && bus.dev_cmd_ready[dev_q];
        fire_vec  = '0;
        if (fire) begin
            fire_vec[dev_q] = 1'b1;
        end
        done_hit  = bus.dev_done & pending;
        rem_after = rem - len_q;
    end

    always_comb begin
        state_nxt         = state;
        bus.req_ready     = (state == ST_IDLE);
        bus.busy_o        = (state != ST_IDLE);
        bus.done_o        = (state == ST_DONE);
        bus.err_o         = (state == ST_DONE) && err_sticky;
        bus.dev_cmd_valid = '0;
        if (issue_ok) begin
            bus.dev_cmd_valid[dev_q] = 1'b1;
        end
        case (state)
            ST_IDLE:  if (accept) state_nxt = (bus.req_blkcnt == '0) ? ST_DONE : ST_CALC;
            ST_CALC:  state_nxt = err_sticky ? ST_DRAIN : ST_ISSUE;
            ST_ISSUE: begin
                if (err_sticky) begin
                    state_nxt = ST_DRAIN;
                end else if (fire) begin
                    state_nxt = (rem_after != '0) ? ST_CALC : ST_DRAIN;
                end
            end
            ST_DRAIN: if (pending == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign bus.dev_cmd_lba    = dlba_q;
    assign bus.dev_cmd_blkcnt = len_q;
    assign bus.dev_cmd_write  = write_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Payload registers hold the chunk stable for the whole ISSUE wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= '0;
            rem        <= '0;
            write_q    <= 1'b0;
            dev_q      <= '0;
            dlba_q     <= '0;
            len_q      <= '0;
            pending    <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (accept) begin
                cur     <= bus.req_lba;
                rem     <= bus.req_blkcnt;
                write_q <= bus.req_write;
            end
            if (state == ST_CALC) begin
                dev_q  <= map_dev;
                dlba_q <= map_dlba;
                len_q  <= map_len;
            end
            if (fire) begin
                cur <= cur + LBA_W'(len_q);
                rem <= rem_after;
            end
            pending <= (pending & ~done_hit) | fire_vec;
            if (state == ST_DONE) begin
                err_sticky <= 1'b0;
            end else if ((done_hit & bus.dev_err) != '0) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_raid0_stripe_scheduler.sv
// Directed bench for the stripe scheduler: a chunk-list model built from the stripe rules
// is checked every cycle, alongside hand-computed expectations for each scenario.
module tb_raid0_stripe_scheduler;

    localparam int NUM_DEV     = 2;
    localparam int STRIPE_BLKS = 8;
    localparam int LBA_W       = 32;
    localparam int BLKCNT_W    = 16;

    typedef struct {
        int                  dev;
        logic [LBA_W-1:0]    lba;
        logic [BLKCNT_W-1:0] cnt;
    } chunk_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    raid0_stripe_scheduler_if #(
        .NUM_DEV  (NUM_DEV),
        .LBA_W    (LBA_W),
        .BLKCNT_W (BLKCNT_W)
    ) bus ();

    raid0_stripe_scheduler #(
        .NUM_DEV     (NUM_DEV),
        .STRIPE_BLKS (STRIPE_BLKS),
        .LBA_W       (LBA_W),
        .BLKCNT_W    (BLKCNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int                 lat[NUM_DEV];
    int                 err_at[NUM_DEV];
    logic [NUM_DEV-1:0] ready_en;

    chunk_t             exp_q[$];
    logic [NUM_DEV-1:0] m_pending;
    bit                 m_err;
    bit                 m_active;
    logic               m_write;
    int                 issued_count;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Expected chunk list straight from the stripe arithmetic.
    task automatic build_model(input logic [LBA_W-1:0] lba, input logic [BLKCNT_W-1:0] cnt);
        logic [LBA_W-1:0] cur;
        int               rem;
        cur = lba;
        rem = int'(cnt);
        exp_q.delete();
        while (rem > 0) begin
            int               off;
            int               len;
            logic [LBA_W-1:0] s;
            chunk_t           c;
            off   = int'(cur % STRIPE_BLKS);
            s     = cur / STRIPE_BLKS;
            len   = (rem < STRIPE_BLKS - off) ? rem : STRIPE_BLKS - off;
            c.dev = int'(s % NUM_DEV);
            c.lba = LBA_W'((s / NUM_DEV) * STRIPE_BLKS + LBA_W'(off));
            c.cnt = BLKCNT_W'(len);
            exp_q.push_back(c);
            cur = cur + LBA_W'(len);
            rem = rem - len;
        end
    endtask

    // Device responder: accepts when enabled, completes each chunk lat[d] cycles later.
    initial begin
        int cnt[NUM_DEV];
        int seq[NUM_DEV];
        bus.dev_cmd_ready = '0;
        bus.dev_done      = '0;
        bus.dev_err       = '0;
        for (int d = 0; d < NUM_DEV; d++) begin
            cnt[d] = 0;
            seq[d] = 0;
        end
        forever begin
            @(negedge clk);
            bus.dev_done = '0;
            bus.dev_err  = '0;
            if (!rst_n) begin
                for (int d = 0; d < NUM_DEV; d++) begin
                    cnt[d] = 0;
                    seq[d] = 0;
                end
                bus.dev_cmd_ready = '0;
            end else begin
                for (int d = 0; d < NUM_DEV; d++) begin
                    if (cnt[d] > 0) begin
                        cnt[d]--;
                        if (cnt[d] == 0) begin
                            bus.dev_done[d] = 1'b1;
                            bus.dev_err[d]  = (seq[d] == err_at[d]);
                            seq[d]++;
                        end
                    end
                end
                bus.dev_cmd_ready = ready_en;
                for (int d = 0; d < NUM_DEV; d++) begin
                    if (bus.dev_cmd_valid[d] && ready_en[d]) cnt[d] = lat[d];
                end
                if (bus.done_o) begin
                    for (int d = 0; d < NUM_DEV; d++) seq[d] = 0;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the chunk-list model.
    initial begin
        chunk_t c;
        exp_q.delete();
        m_pending    = '0;
        m_err        = 1'b0;
        m_active     = 1'b0;
        m_write      = 1'b0;
        issued_count = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                check_output("rst_cmd_valid", 64'(bus.dev_cmd_valid), 64'(0));
                check_output("rst_req_ready", 64'(bus.req_ready), 64'(1));
                check_output("rst_busy", 64'(bus.busy_o), 64'(0));
                check_output("rst_done", 64'(bus.done_o), 64'(0));
                check_output("rst_err", 64'(bus.err_o), 64'(0));
                exp_q.delete();
                m_pending = '0;
                m_err     = 1'b0;
                m_active  = 1'b0;
            end else begin
                check_output("busy", 64'(bus.busy_o), 64'(m_active));
                check_output("req_ready", 64'(bus.req_ready), 64'(!m_active));
                if (bus.done_o) begin
                    check_output("done_while_idle", 64'(m_active), 64'(1));
                    check_output("done_with_pending", 64'(m_pending), 64'(0));
                    check_output("done_chunks_left", 64'(m_err ? 0 : exp_q.size()), 64'(0));
                    check_output("err_o", 64'(bus.err_o), 64'(m_err));
                end else begin
                    check_output("err_without_done", 64'(bus.err_o), 64'(0));
                end
                if (bus.dev_cmd_valid != '0) begin
                    check_output("valid_onehot", 64'($onehot(bus.dev_cmd_valid)), 64'(1));
                    check_output("valid_after_err", 64'(m_err), 64'(0));
                    if (exp_q.size() == 0) begin
                        check_output("valid_unexpected", 64'(bus.dev_cmd_valid), 64'(0));
                    end else begin
                        c = exp_q[0];
                        check_output("cmd_dev", 64'(bus.dev_cmd_valid), 64'(1) << c.dev);
                        check_output("cmd_lba", 64'(bus.dev_cmd_lba), 64'(c.lba));
                        check_output("cmd_cnt", 64'(bus.dev_cmd_blkcnt), 64'(c.cnt));
                        check_output("cmd_write", 64'(bus.dev_cmd_write), 64'(m_write));
                        check_output("cmd_while_pending", 64'(bus.dev_cmd_valid & m_pending), 64'(0));
                        if ((bus.dev_cmd_valid & bus.dev_cmd_ready) != '0) begin
                            void'(exp_q.pop_front());
                            m_pending = m_pending | bus.dev_cmd_valid;
                            issued_count++;
                        end
                    end
                end
                for (int d = 0; d < NUM_DEV; d++) begin
                    if (bus.dev_done[d] && m_pending[d]) begin
                        m_pending[d] = 1'b0;
                        if (bus.dev_err[d]) m_err = 1'b1;
                    end
                end
                if (bus.done_o) begin
                    m_active = 1'b0;
                    m_err    = 1'b0;
                end
                if (bus.req_valid && bus.req_ready) begin
                    build_model(bus.req_lba, bus.req_blkcnt);
                    m_active     = 1'b1;
                    m_err        = 1'b0;
                    m_write      = bus.req_write;
                    issued_count = 0;
                end
            end
        end
    end

    // Presents one request for one cycle; returns at the edge after acceptance.
    task automatic apply_stimulus(input logic [LBA_W-1:0] lba, input logic [BLKCNT_W-1:0] cnt, input logic wr);
        @(negedge clk);
        bus.req_lba    = lba;
        bus.req_blkcnt = cnt;
        bus.req_write  = wr;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            #2;
            if (bus.done_o) got = 1'b1;
        end
        if (!got) check_output("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic set_devices(input int l0, input int l1, input logic [NUM_DEV-1:0] rdy);
        lat[0]   = l0;
        lat[1]   = l1;
        ready_en = rdy;
    endtask

    initial begin
        bit seen;
        bus.req_valid  = 1'b0;
        bus.req_lba    = '0;
        bus.req_blkcnt = '0;
        bus.req_write  = 1'b0;
        err_at[0] = -1;
        err_at[1] = -1;
        set_devices(2, 2, 2'b11);

        repeat (3) @(negedge clk);
        #2;
        check_output("reset_req_ready", 64'(bus.req_ready), 64'(1));
        check_output("reset_busy", 64'(bus.busy_o), 64'(0));
        #1 rst_n = 1'b1;

        // Aligned two-stripe write.
        apply_stimulus(32'd0, 16'd16, 1'b1);
        #2;
        check_output("t1_calc_no_valid", 64'(bus.dev_cmd_valid), 64'(0));
        @(negedge clk); #2;
        check_output("t1_first_dev", 64'(bus.dev_cmd_valid), 64'(2'b01));
        check_output("t1_first_lba", 64'(bus.dev_cmd_lba), 64'(0));
        check_output("t1_first_cnt", 64'(bus.dev_cmd_blkcnt), 64'(8));
        check_output("t1_first_write", 64'(bus.dev_cmd_write), 64'(1));
        @(negedge clk); @(negedge clk); #2;
        check_output("t1_second_dev", 64'(bus.dev_cmd_valid), 64'(2'b10));
        check_output("t1_second_lba", 64'(bus.dev_cmd_lba), 64'(0));
        check_output("t1_second_cnt", 64'(bus.dev_cmd_blkcnt), 64'(8));
        wait_done(40);
        check_output("t1_err", 64'(bus.err_o), 64'(0));
        check_output("t1_issued", 64'(issued_count), 64'(2));

        // Unaligned head, short tail, read.
        apply_stimulus(32'd5, 16'd10, 1'b0);
        @(negedge clk); #2;
        check_output("t2_head_dev", 64'(bus.dev_cmd_valid), 64'(2'b01));
        check_output("t2_head_lba", 64'(bus.dev_cmd_lba), 64'(5));
        check_output("t2_head_cnt", 64'(bus.dev_cmd_blkcnt), 64'(3));
        check_output("t2_head_write", 64'(bus.dev_cmd_write), 64'(0));
        @(negedge clk); @(negedge clk); #2;
        check_output("t2_tail_dev", 64'(bus.dev_cmd_valid), 64'(2'b10));
        check_output("t2_tail_lba", 64'(bus.dev_cmd_lba), 64'(0));
        check_output("t2_tail_cnt", 64'(bus.dev_cmd_blkcnt), 64'(7));
        wait_done(40);
        check_output("t2_err", 64'(bus.err_o), 64'(0));
        check_output("t2_issued", 64'(issued_count), 64'(2));

        // Slow dev0: its second chunk must wait for the completion.
        set_devices(20, 2, 2'b11);
        apply_stimulus(32'd0, 16'd24, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); #2;
            if (bus.dev_done[0]) seen = 1'b1;
        end
        check_output("t3_dev0_done_seen", 64'(seen), 64'(1));
        check_output("t3_held_at_done", 64'(bus.dev_cmd_valid[0]), 64'(0));
        check_output("t3_dev1_ran", 64'(issued_count), 64'(2));
        @(negedge clk); #2;
        check_output("t3_reissue_dev", 64'(bus.dev_cmd_valid), 64'(2'b01));
        check_output("t3_reissue_lba", 64'(bus.dev_cmd_lba), 64'(8));
        check_output("t3_reissue_cnt", 64'(bus.dev_cmd_blkcnt), 64'(8));
        wait_done(60);
        check_output("t3_err", 64'(bus.err_o), 64'(0));
        check_output("t3_issued", 64'(issued_count), 64'(3));
        set_devices(2, 2, 2'b11);

        // Zero-length request.
        apply_stimulus(32'd100, 16'd0, 1'b1);
        #2;
        check_output("t4_done", 64'(bus.done_o), 64'(1));
        check_output("t4_err", 64'(bus.err_o), 64'(0));
        check_output("t4_no_valid", 64'(bus.dev_cmd_valid), 64'(0));
        @(negedge clk); #2;
        check_output("t4_done_pulse", 64'(bus.done_o), 64'(0));
        check_output("t4_idle_ready", 64'(bus.req_ready), 64'(1));

        // First dev0 chunk fails: no further issue, error reported after drain.
        set_devices(3, 3, 2'b11);
        err_at[0] = 0;
        apply_stimulus(32'd0, 16'd24, 1'b1);
        wait_done(40);
        check_output("t5_err", 64'(bus.err_o), 64'(1));
        check_output("t5_issued", 64'(issued_count), 64'(2));
        err_at[0] = -1;
        set_devices(2, 2, 2'b11);

        // Reset while stalled in ISSUE.
        set_devices(2, 2, 2'b00);
        apply_stimulus(32'd16, 16'd8, 1'b1);
        @(negedge clk); #2;
        check_output("t6_stall_dev", 64'(bus.dev_cmd_valid), 64'(2'b01));
        check_output("t6_stall_lba", 64'(bus.dev_cmd_lba), 64'(8));
        @(negedge clk); #2;
        check_output("t6_still_stalled", 64'(bus.dev_cmd_valid), 64'(2'b01));
        #1 rst_n = 1'b0;
        #1;
        check_output("t6_rst_valid", 64'(bus.dev_cmd_valid), 64'(0));
        check_output("t6_rst_busy", 64'(bus.busy_o), 64'(0));
        check_output("t6_rst_ready", 64'(bus.req_ready), 64'(1));
        check_output("t6_rst_done", 64'(bus.done_o), 64'(0));
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        set_devices(2, 2, 2'b11);
        apply_stimulus(32'd8, 16'd4, 1'b0);
        @(negedge clk); #2;
        check_output("t6_fresh_dev", 64'(bus.dev_cmd_valid), 64'(2'b10));
        check_output("t6_fresh_lba", 64'(bus.dev_cmd_lba), 64'(0));
        check_output("t6_fresh_cnt", 64'(bus.dev_cmd_blkcnt), 64'(4));
        wait_done(40);
        check_output("t6_err", 64'(bus.err_o), 64'(0));

        // Request straddling the top of the address space wraps to LBA 0.
        apply_stimulus(32'hFFFF_FFFC, 16'd8, 1'b1);
        @(negedge clk); #2;
        check_output("t7_head_dev", 64'(bus.dev_cmd_valid), 64'(2'b10));
        check_output("t7_head_lba", 64'(bus.dev_cmd_lba), 64'(32'h7FFF_FFFC));
        check_output("t7_head_cnt", 64'(bus.dev_cmd_blkcnt), 64'(4));
        wait_done(40);
        check_output("t7_issued", 64'(issued_count), 64'(2));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
